jtag_debug_cmd_sync: RTL

JTAG_DEBUG_CMD_SYNC -- requirements
Module: jtag_debug_cmd_sync

---
 rtl/jtag_debug_cmd_sync_if.sv | 28 ++
 rtl/jtag_debug_cmd_sync.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_cmd_sync_if.sv
// Command stream from the JTAG debug synchronizer to its consumer.
//   cmd_valid : FIFO head is valid (producer -> consumer)
//   cmd_ready : consumer accepts the head (consumer -> producer)
//   cmd_ir    : instruction of the FIFO head
//   jdo       : data-register contents of the FIFO head
interface jtag_debug_cmd_sync_if #(
    parameter int unsigned IR_WIDTH = 2,
    parameter int unsigned DR_WIDTH = 38
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] jdo;

    modport master (
        output cmd_valid,
        output cmd_ir,
        output jdo,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ir,
        input  jdo,
        output cmd_ready
    );
endinterface

// File: rtl/jtag_debug_cmd_sync.sv
// Moves virtual-JTAG update strobes from the TCK domain into clk, queues each
// update-DR as an {ir, dr} command in a first-word-fall-through FIFO, and turns
// every consumed command into a per-channel action / no-action strobe.
// Ports:
//   clk, reset      : system clock, asynchronous active-high reset
//   vs_udr, vs_uir  : TCK-domain update-DR / update-IR strobes (async to clk)
//   ir_in, sr       : quasi-static instruction and shift-register buses
//   cmd             : command stream (valid/ready, cmd_ir, jdo), master side
//   take_action     : one-hot per channel, pulses after a pop with action bit 1
//   take_no_action  : one-hot per channel, pulses after a pop with action bit 0
//   ir_update       : one-cycle pulse per synchronized update-IR rise
//   fill_level      : number of queued commands
//   overflow        : sticky, set when a command is dropped on a full FIFO
//   clear_overflow  : synchronous clear of overflow
module jtag_debug_cmd_sync #(
    parameter int unsigned IR_WIDTH    = 2,
    parameter int unsigned DR_WIDTH    = 38,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    input  logic [IR_WIDTH-1:0]           ir_in,
    input  logic [DR_WIDTH-1:0]           sr,
    jtag_debug_cmd_sync_if.master         cmd,
    output logic [(2**IR_WIDTH)-1:0]      take_action,
    output logic [(2**IR_WIDTH)-1:0]      take_no_action,
    output logic                          ir_update,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int unsigned NCH = 2**IR_WIDTH;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned EW  = IR_WIDTH + DR_WIDTH;

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_edge;
    logic                   uir_edge;
    logic                   udr_rise;
    logic                   uir_rise;

    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [EW-1:0]          wdata;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;

    logic [PW-1:0]          wr_ptr_n;
    logic [PW-1:0]          rd_ptr_n;
    logic [CW-1:0]          fill_n;
    logic [EW-1:0]          head_n;
    logic                   overflow_n;
    logic [NCH-1:0]         take_action_n;
    logic [NCH-1:0]         take_no_action_n;

    // Strobe synchronizers; reset to 1 so a strobe already high at release is not a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_sync <= '1;
            uir_sync <= '1;
            udr_edge <= 1'b1;
            uir_edge <= 1'b1;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_edge <= udr_sync[SYNC_STAGES-1];
            uir_edge <= uir_sync[SYNC_STAGES-1];
        end
    end

    assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_edge;
    assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_edge;

    // ir_in/sr are quasi-static once the strobe is seen, so they are sampled unsynchronized.
    assign wdata = {ir_in, sr};
    assign full  = (fill_level == CW'(FIFO_DEPTH));
    assign pop   = cmd.cmd_valid & cmd.cmd_ready;
    assign push  = udr_rise & (~full | pop);
    assign drop  = udr_rise & full & ~pop;

    // Command storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Next-state for pointers, level, registered head and strobes.
    always_comb begin
        wr_ptr_n         = wr_ptr;
        rd_ptr_n         = rd_ptr;
        fill_n           = fill_level;
        head_n           = '0;
        overflow_n       = overflow;
        take_action_n    = '0;
        take_no_action_n = '0;

        if (push) begin
            wr_ptr_n = wr_ptr + PW'(1);
        end
        if (pop) begin
            rd_ptr_n = rd_ptr + PW'(1);
        end
        if (push && !pop) begin
            fill_n = fill_level + CW'(1);
        end else if (!push && pop) begin
            fill_n = fill_level - CW'(1);
        end

        // A push landing in the slot that becomes the head is not yet in mem.
        if (push && (wr_ptr == rd_ptr_n)) begin
            head_n = wdata;
        end else if (fill_n != '0) begin
            head_n = mem[rd_ptr_n];
        end

        if (drop) begin
            overflow_n = 1'b1;
        end else if (clear_overflow) begin
            overflow_n = 1'b0;
        end

        if (pop) begin
            if (cmd.jdo[DR_WIDTH-1]) begin
                take_action_n = NCH'(1) << cmd.cmd_ir;
            end else begin
                take_no_action_n = NCH'(1) << cmd.cmd_ir;
            end
        end
    end

    // Output and FIFO state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill_level     <= '0;
            cmd.cmd_valid  <= 1'b0;
            cmd.cmd_ir     <= '0;
            cmd.jdo        <= '0;
            overflow       <= 1'b0;
            take_action    <= '0;
            take_no_action <= '0;
            ir_update      <= 1'b0;
        end else begin
            wr_ptr                 <= wr_ptr_n;
            rd_ptr                 <= rd_ptr_n;
            fill_level             <= fill_n;
            cmd.cmd_valid          <= (fill_n != '0);
            {cmd.cmd_ir, cmd.jdo}  <= head_n;
            overflow               <= overflow_n;
            take_action            <= take_action_n;
            take_no_action         <= take_no_action_n;
            ir_update              <= uir_rise;
        end
    end

endmodule
